unified_mem_arb: RTL and testbench

Arbiter that shares one single-port synchronous RAM between the instruction-fetch port and the data read/write ports of the five-stage core. It sits between the core's instruction-memory and data-memory interfaces and the RAM macro. Per cycle it grants at most one access with fixed priority (write > data read > fetch) and a starvation guard for fetch. It tags each read so the one-cycle-later RAM data is returned to the correct requester.

---
 rtl/unified_mem_arb_if.sv | 37 +++
 rtl/unified_mem_arb.sv | 61 ++++++
 tb/tb_unified_mem_arb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arb_if.sv
// unified_mem_arb_if: core fetch/data request ports and single-port RAM port
// shared by the arbiter (slave) and the requesters plus RAM macro (master).
interface unified_mem_arb_if #(
    parameter int AW = 14
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_we;
    logic [31:0]   d_waddr;
    logic [31:0]   d_wdata;
    logic          d_wgnt;
    logic          d_re;
    logic [31:0]   d_raddr;
    logic          d_rgnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    modport slave (
        input  if_req, if_addr, d_we, d_waddr, d_wdata, d_re, d_raddr, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, d_wgnt, d_rgnt, d_rvalid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, d_we, d_waddr, d_wdata, d_re, d_raddr, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_wgnt, d_rgnt, d_rvalid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/unified_mem_arb.sv
// unified_mem_arb: shares one single-port RAM between fetch and data ports with
// fixed priority (write > read > fetch), a fetch starvation guard and read tagging.
module unified_mem_arb #(
    parameter int AW         = 14,
    parameter int STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst_n,
    unified_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_DATA} tag_e;

    tag_e       rd_tag_q, rd_tag_d;
    logic [3:0] starve_q, starve_d;
    logic       fetch_pri;
    logic       w_gnt;
    logic       r_gnt;
    logic       f_gnt;
    logic       unused_ok;

    // Grants are masked by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        fetch_pri = (starve_q == 4'(STARVE_MAX)) && bus.if_req;
        w_gnt     = rst_n && !fetch_pri && bus.d_we;
        r_gnt     = rst_n && !fetch_pri && !bus.d_we && bus.d_re;
        f_gnt     = rst_n && bus.if_req && !w_gnt && !r_gnt;
        rd_tag_d  = f_gnt ? TAG_IF : r_gnt ? TAG_DATA : TAG_NONE;
        starve_d  = (!bus.if_req || f_gnt) ? 4'd0 :
                    (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag_q <= TAG_NONE;
            starve_q <= 4'd0;
        end else begin
            rd_tag_q <= rd_tag_d;
            starve_q <= starve_d;
        end
    end

    assign bus.if_gnt    = f_gnt;
    assign bus.d_wgnt    = w_gnt;
    assign bus.d_rgnt    = r_gnt;
    assign bus.ram_en    = w_gnt || r_gnt || f_gnt;
    assign bus.ram_we    = w_gnt;
    assign bus.ram_wdata = bus.d_wdata;
    assign bus.ram_addr  = w_gnt ? bus.d_waddr[AW+1:2] :
                           r_gnt ? bus.d_raddr[AW+1:2] :
                           f_gnt ? bus.if_addr[AW+1:2] : '0;

    // RAM data lands one cycle after the grant; the tag steers it to its requester.
    assign bus.if_rvalid = (rd_tag_q == TAG_IF);
    assign bus.d_rvalid  = (rd_tag_q == TAG_DATA);
    assign bus.if_rdata  = bus.if_rvalid ? bus.ram_rdata : 32'd0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.ram_rdata : 32'd0;

    assign unused_ok = ^{bus.if_addr[31:AW+2], bus.if_addr[1:0],
                         bus.d_waddr[31:AW+2], bus.d_waddr[1:0],
                         bus.d_raddr[31:AW+2], bus.d_raddr[1:0]};
endmodule

// File: tb/tb_unified_mem_arb.sv
// tb_unified_mem_arb: directed plus random stimulus against a priority/queue
// reference model and a behavioural single-port RAM.
module tb_unified_mem_arb;
    localparam int AW   = 14;
    localparam int SMAX = 3;
    localparam int W_NONE = 0, W_IF = 1, W_WR = 2, W_RD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    unified_mem_arb_if #(.AW(AW)) bus ();
    unified_mem_arb #(.AW(AW), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    logic [31:0] shadow [int];
    int          m_denied = 0;
    int          m_tag = 0;
    logic [31:0] m_data = 0;
    int          m_win = W_NONE;

    function automatic int wa(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << AW));
    endfunction

    function automatic logic [31:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check();
        int ea;
        #1;
        if (!rst_n) begin
            m_denied = 0;
            m_tag = 0;
        end
        m_win = W_NONE;
        if (rst_n) begin
            if (bus.if_req && m_denied >= SMAX) m_win = W_IF;
            else if (bus.d_we) m_win = W_WR;
            else if (bus.d_re) m_win = W_RD;
            else if (bus.if_req) m_win = W_IF;
        end
        ea = (m_win == W_WR) ? wa(bus.d_waddr) : (m_win == W_RD) ? wa(bus.d_raddr) :
             (m_win == W_IF) ? wa(bus.if_addr) : 0;
        chk("if_gnt", 32'(bus.if_gnt), 32'(m_win == W_IF));
        chk("d_wgnt", 32'(bus.d_wgnt), 32'(m_win == W_WR));
        chk("d_rgnt", 32'(bus.d_rgnt), 32'(m_win == W_RD));
        chk("ram_en", 32'(bus.ram_en), 32'(m_win != W_NONE));
        chk("ram_we", 32'(bus.ram_we), 32'(m_win == W_WR));
        chk("ram_addr", 32'(bus.ram_addr), 32'(ea));
        chk("ram_wdata", bus.ram_wdata, bus.d_wdata);
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(m_tag == 1));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_tag == 2));
        chk("if_rdata", bus.if_rdata, (m_tag == 1) ? m_data : 32'd0);
        chk("d_rdata", bus.d_rdata, (m_tag == 2) ? m_data : 32'd0);
        chk("starve", 32'(dut.starve_q), 32'(m_denied));
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            m_tag = 0;
            m_denied = 0;
        end else begin
            m_tag = (m_win == W_IF) ? 1 : (m_win == W_RD) ? 2 : 0;
            if (m_win == W_IF) m_data = shadow_rd(wa(bus.if_addr));
            if (m_win == W_RD) m_data = shadow_rd(wa(bus.d_raddr));
            if (m_win == W_WR) shadow[wa(bus.d_waddr)] = bus.d_wdata;
            m_denied = (bus.if_req && m_win != W_IF) ? ((m_denied < SMAX) ? m_denied + 1 : SMAX) : 0;
        end
        @(negedge clk);
    endtask

    task automatic clr();
        bus.if_req = 0; bus.d_we = 0; bus.d_re = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        return ($urandom << (AW + 2)) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    logic [31:0] words [0:7];

    initial begin
        clr();
        bus.if_addr = 0; bus.d_waddr = 0; bus.d_wdata = 0; bus.d_raddr = 0;
        @(negedge clk);
        bus.if_req = 1; bus.d_we = 1; bus.d_re = 1;
        check();
        adv();
        clr();
        rst_n = 1;
        // preload words 0..7 through the arbiter; 0..2 hold A, B, C
        words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
        for (int i = 3; i < 8; i++) words[i] = $urandom;
        for (int i = 0; i < 8; i++) begin
            bus.d_we = 1; bus.d_waddr = 32'(i) << 2; bus.d_wdata = words[i];
            check();
            adv();
        end
        clr();
        for (int i = 0; i < 4; i++) begin
            bus.if_req = (i < 3); bus.if_addr = 32'(i) << 2;
            check();
            if (i < 3) begin
                chk("fetch_gnt", 32'(bus.if_gnt), 32'd1);
                chk("fetch_addr", 32'(bus.ram_addr), 32'(i));
            end
            if (i > 0) chk("fetch_data", bus.if_rdata, words[i-1]);
            adv();
        end
        clr();
        bus.d_we = 1; bus.d_waddr = 32'h40; bus.d_wdata = 32'hDEADBEEF;
        bus.d_re = 1; bus.d_raddr = 32'h40;
        check();
        chk("wr_first", {30'd0, bus.d_wgnt, bus.d_rgnt}, 32'd2);
        adv();
        bus.d_we = 0;
        check();
        chk("rd_second", 32'(bus.d_rgnt), 32'd1);
        adv();
        bus.d_re = 0;
        check();
        chk("raw_data", bus.d_rdata, 32'hDEADBEEF);
        chk("raw_valid", 32'(bus.d_rvalid), 32'd1);
        adv();
        bus.if_req = 1; bus.if_addr = 32'h8; bus.d_re = 1; bus.d_raddr = 32'h4;
        for (int i = 0; i < 5; i++) begin
            check();
            chk("starve_gnt", {30'd0, bus.if_gnt, bus.d_rgnt}, (i == 3) ? 32'd2 : 32'd1);
            if (i == 4) chk("starve_clr", 32'(dut.starve_q), 32'd0);
            adv();
        end
        clr();
        for (int i = 0; i < 6; i++) begin
            bus.d_re = i[0]; bus.if_req = !i[0];
            bus.d_raddr = 32'(i) << 2; bus.if_addr = 32'(7 - i) << 2;
            check();
            adv();
        end
        clr();
        check();
        adv();
        bus.if_req = 1; bus.if_addr = 32'hC;
        check();
        #2 rst_n = 0;
        check();
        chk("rst_gnt", {29'd0, bus.if_gnt, bus.ram_en, bus.if_rvalid}, 32'd0);
        adv();
        check();
        adv();
        rst_n = 1; clr();
        check();
        chk("rst_no_rvalid", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        adv();
        bus.if_req = 1;
        check();
        chk("post_rst_gnt", 32'(bus.if_gnt), 32'd1);
        adv();
        clr();
        for (int i = 0; i < 11; i++) begin
            check();
            adv();
        end
        chk("idle_starve", 32'(dut.starve_q), 32'd0);
        for (int i = 0; i < 400; i++) begin
            bus.if_req = ($urandom_range(0, 3) != 0);
            bus.d_we = ($urandom_range(0, 3) == 0);
            bus.d_re = ($urandom_range(0, 2) == 0);
            bus.if_addr = rnd_addr(); bus.d_waddr = rnd_addr(); bus.d_raddr = rnd_addr();
            bus.d_wdata = $urandom;
            check();
            adv();
        end
        clr();
        check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
